// File: rtl/ring_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ring_rr_arbiter
//
// Round-robin arbiter sharing one downstream resource among N requesters.
// A one-hot rotating priority token, held in flops, selects which requester
// is searched first. Grants are registered, one-hot and sticky: a grant is
// held while its requester keeps req high. When the owner releases, the grant
// moves to the next eligible requester at the same edge (no idle bubble), and
// the token advances to just past the newly granted index so that the
// requester just served has the lowest priority next time.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   A hold counter limits a grant to MAX_HOLD consecutive cycles while some
//   other requester is waiting. On preemption the owner is excluded from the
//   search for that edge and timeout pulses for one cycle together with the
//   new grant. Without the macro grants are held indefinitely and timeout is
//   tied low.
//
// Parameters:
//   N        number of requesters (>= 2)
//   MAX_HOLD maximum consecutive grant cycles before preemption (>= 1),
//            only meaningful with ARB_TIMEOUT_EN
//
// Ports:
//   clk      in   1           clock, rising edge
//   reset    in   1           asynchronous, active-high reset
//   req      in   N           request per requester, held while wanted
//   grant    out  N           registered one-hot grant, zero when idle
//   owner    out  clog2(N)    index of the grant holder, 0 when idle
//   busy     out  1           OR of the grant flops
//   token    out  N           one-hot priority pointer (search start)
//   timeout  out  1           one-cycle pulse on preemption
// ----------------------------------------------------------------------------
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [N-1:0]         token,
    output logic                 timeout
);

    localparam int OW = $clog2(N);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [N-1:0]   token_q, token_d;

    logic           keep;
    logic           preempt;
    logic           new_grant;
    logic [N-1:0]   elig;
    logic [OW-1:0]  tok_idx;
    logic [2*N-1:0] elig_dbl;
    logic [N-1:0]   elig_rot;
    logic           pick_found;
    logic [OW-1:0]  pick_idx;
    logic [N-1:0]   pick_oh;

    // Current owner continues only while its request stays high.
    assign keep = (state_q == GRANTED) && req[owner_q];

`ifdef ARB_TIMEOUT_EN
    // Counter must be able to hold MAX_HOLD-1; the +1 keeps the width >= 1
    // when MAX_HOLD is 1.
    localparam int            HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
    logic          others_req;

    // While keep is true grant_q is the owner's one-hot, so masking it out
    // leaves exactly the competing requests.
    assign others_req = |(req & ~grant_q);
    assign preempt    = keep && (hold_q == HOLD_LAST) && others_req;
`else
    logic unused_hold_cfg;

    assign preempt         = 1'b0;
    assign unused_hold_cfg = (MAX_HOLD >= 1);
`endif

    // On preemption the owner sits out this edge's search.
    assign elig = preempt ? (req & ~grant_q) : req;

    // One-hot token to index.
    always_comb begin
        tok_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (token_q[i]) begin
                tok_idx = OW'(i);
            end
        end
    end

    // Rotate the eligible set so the token position lands on bit 0; the
    // lowest set bit of the rotated vector is then the first hit of the
    // circular search. Scanning downward lets the lowest offset win.
    assign elig_dbl = {elig, elig} >> tok_idx;
    assign elig_rot = elig_dbl[N-1:0];

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                pick_found = 1'b1;
                pick_idx   = OW'((int'(tok_idx) + i) % N);
            end
        end
    end

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Next-state / grant / token.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        token_d   = token_q;
        new_grant = 1'b0;

        if (keep && !preempt) begin
            state_d = GRANTED;
        end else if (pick_found) begin
            state_d   = GRANTED;
            grant_d   = pick_oh;
            owner_d   = pick_idx;
            // Token moves one past the winner, wrapping bit N-1 to bit 0.
            token_d   = {pick_oh[N-2:0], pick_oh[N-1]};
            new_grant = 1'b1;
        end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            token_q <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            token_q <= token_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counter clears on every new grant and saturates at MAX_HOLD-1 so that
    // an uncontested owner is preempted at the first edge a rival appears.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = preempt;
        if (new_grant) begin
            hold_d = '0;
        end else if (keep && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant = grant_q;
    assign owner = owner_q;
    assign token = token_q;
    assign busy  = |grant_q;

endmodule
